// File: rtl/seg_pkg.sv
// Shared types and the hex seven-segment glyph table for the seg_counter block.
package seg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Segment glyphs for 0..F; bit0 = a ... bit6 = g, active-high.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        return HEX7_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit to seven-segment glyph lookup.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    // Table lookup of the glyph for one hex digit.
    always_comb begin
        segs = hex7(nibble);
    end

endmodule

// File: rtl/seg_counter.sv
// Prescaled up/down/load counter with a registered, digit-selectable hex display.
module seg_counter
    import seg_pkg::*;
#(
    parameter  int unsigned NBITS   = 8,
    parameter  int unsigned DIV     = 4,
    localparam int unsigned NDIGITS = NBITS / 4,
    localparam int unsigned DSEL_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic [NBITS-1:0]  load_val,
    input  logic [DSEL_W-1:0] digit_sel,
    input  logic              blank,
    input  logic              clr_flag,
    output logic [NBITS-1:0]  count,
    output logic              tick,
    output logic              wrap_flag,
    output logic [7:0]        seg
);

    if ((NBITS % 4) != 0 || NBITS == 0) begin : g_bad_nbits
        $error("seg_counter: NBITS must be a non-zero multiple of 4");
    end
    if (DIV < 1) begin : g_bad_div
        $error("seg_counter: DIV must be at least 1");
    end

    localparam int unsigned      PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [NBITS-1:0] CNT_MAX  = '1;

    mode_e            mode_q;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic [NBITS-1:0] count_nxt;
    logic             tick_nxt;
    logic             flag_nxt;
    int unsigned      dsel_int;
    logic [3:0]       nibble;
    logic [6:0]       hex_segs;
    logic [7:0]       seg_nxt;

    assign mode_q   = mode_e'(mode);
    assign dsel_int = 32'(digit_sel);

    // Next counter, prescaler, tick and flag; flag priority is load > wrap > clr_flag > hold.
    always_comb begin
        pre_nxt   = '0;
        count_nxt = count;
        tick_nxt  = 1'b0;
        flag_nxt  = clr_flag ? 1'b0 : wrap_flag;
        case (mode_q)
            MODE_UP, MODE_DOWN: begin
                if (pre == PRE_LAST) begin
                    tick_nxt = 1'b1;
                    if (mode_q == MODE_UP) begin
                        count_nxt = count + NBITS'(1);
                        if (count == CNT_MAX) flag_nxt = 1'b1;
                    end else begin
                        count_nxt = count - NBITS'(1);
                        if (count == '0) flag_nxt = 1'b1;
                    end
                end else begin
                    pre_nxt = pre + PRE_W'(1);
                end
            end
            MODE_LOAD: begin
                count_nxt = load_val;
                flag_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    // Shifting rather than a +: part-select keeps out-of-range digit_sel harmless.
    assign nibble = 4'(count >> (dsel_int * 4));

    seg_hex_decoder u_hex (
        .nibble (nibble),
        .segs   (hex_segs)
    );

    // Display value derived from the currently registered count and flag.
    always_comb begin
        seg_nxt = {wrap_flag, hex_segs};
        if (blank || dsel_int >= NDIGITS) seg_nxt = SEG_BLANK;
    end

    // State and display registers.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            pre       <= '0;
            tick      <= 1'b0;
            wrap_flag <= 1'b0;
            seg       <= SEG_BLANK;
        end else begin
            count     <= count_nxt;
            pre       <= pre_nxt;
            tick      <= tick_nxt;
            wrap_flag <= flag_nxt;
            seg       <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_counter.sv
// Self-checking bench: three seg_counter configurations against a cycle-level reference model.
module tb_seg_counter;

    logic        clk_2 = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  ld8 = '0;
    logic [11:0] ld12 = '0;
    logic        dsel8 = 1'b0;
    logic [1:0]  dsel12 = '0;
    logic        blank = 1'b0;
    logic        clr_flag = 1'b0;

    logic [7:0]  count_a, count_b, seg_a, seg_b, seg_c;
    logic [11:0] count_c;
    logic        tick_a, tick_b, tick_c, flag_a, flag_b, flag_c;

    int errors = 0;
    int checks = 0;

    always #5 clk_2 = ~clk_2;

    seg_counter #(.NBITS(8), .DIV(4)) dut_a (
        .clk_2(clk_2), .reset_n(reset_n), .mode(mode), .load_val(ld8),
        .digit_sel(dsel8), .blank(blank), .clr_flag(clr_flag),
        .count(count_a), .tick(tick_a), .wrap_flag(flag_a), .seg(seg_a)
    );

    seg_counter #(.NBITS(8), .DIV(1)) dut_b (
        .clk_2(clk_2), .reset_n(reset_n), .mode(mode), .load_val(ld8),
        .digit_sel(dsel8), .blank(blank), .clr_flag(clr_flag),
        .count(count_b), .tick(tick_b), .wrap_flag(flag_b), .seg(seg_b)
    );

    seg_counter #(.NBITS(12), .DIV(4)) dut_c (
        .clk_2(clk_2), .reset_n(reset_n), .mode(mode), .load_val(ld12),
        .digit_sel(dsel12), .blank(blank), .clr_flag(clr_flag),
        .count(count_c), .tick(tick_c), .wrap_flag(flag_c), .seg(seg_c)
    );

    // Reference model: one entry per instance (0 = a, 1 = b, 2 = c).
    int nb [3] = '{8, 8, 12};
    int dv [3] = '{4, 1, 4};
    int hex_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                         'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
    int m_cnt [3];
    int m_pre [3];
    int m_flg [3];
    int m_tck [3];
    int m_seg [3];

    function automatic int in_ld(int i);
        return (i == 2) ? int'(ld12) : int'(ld8);
    endfunction

    function automatic int in_ds(int i);
        return (i == 2) ? int'(dsel12) : int'(dsel8);
    endfunction

    function automatic int act_cnt(int i);
        case (i)
            0: return int'(count_a);
            1: return int'(count_b);
            default: return int'(count_c);
        endcase
    endfunction

    function automatic int act_tck(int i);
        case (i)
            0: return int'(tick_a);
            1: return int'(tick_b);
            default: return int'(tick_c);
        endcase
    endfunction

    function automatic int act_flg(int i);
        case (i)
            0: return int'(flag_a);
            1: return int'(flag_b);
            default: return int'(flag_c);
        endcase
    endfunction

    function automatic int act_seg(int i);
        case (i)
            0: return int'(seg_a);
            1: return int'(seg_b);
            default: return int'(seg_c);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_flg[i] = 0; m_tck[i] = 0; m_seg[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_cnt%0d", tag, i), act_cnt(i), m_cnt[i]);
            chk($sformatf("%s_tick%0d", tag, i), act_tck(i), m_tck[i]);
            chk($sformatf("%s_flag%0d", tag, i), act_flg(i), m_flg[i]);
            chk($sformatf("%s_seg%0d", tag, i), act_seg(i), m_seg[i]);
        end
    endtask

    // One clock: predict from current inputs/state, take the edge, compare.
    task automatic cycle();
        int n_cnt [3];
        int n_pre [3];
        int n_flg [3];
        int n_tck [3];
        int n_seg [3];
        for (int i = 0; i < 3; i++) begin
            int mx, ds;
            mx = (1 << nb[i]) - 1;
            ds = in_ds(i);
            n_cnt[i] = m_cnt[i]; n_pre[i] = 0; n_tck[i] = 0;
            n_flg[i] = clr_flag ? 0 : m_flg[i];
            if (mode == 2'b11) begin
                n_cnt[i] = in_ld(i);
                n_flg[i] = 0;
            end else if (mode != 2'b00) begin
                if (m_pre[i] == dv[i] - 1) begin
                    n_tck[i] = 1;
                    if (mode == 2'b01) begin
                        n_cnt[i] = (m_cnt[i] + 1) & mx;
                        if (m_cnt[i] == mx) n_flg[i] = 1;
                    end else begin
                        n_cnt[i] = (m_cnt[i] - 1) & mx;
                        if (m_cnt[i] == 0) n_flg[i] = 1;
                    end
                end else begin
                    n_pre[i] = m_pre[i] + 1;
                end
            end
            if (blank || ds >= nb[i] / 4)
                n_seg[i] = 0;
            else
                n_seg[i] = (m_flg[i] << 7) | hex_tab[(m_cnt[i] >> (4 * ds)) & 15];
        end
        @(posedge clk_2);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = n_cnt[i]; m_pre[i] = n_pre[i]; m_flg[i] = n_flg[i];
            m_tck[i] = n_tck[i]; m_seg[i] = n_seg[i];
        end
        check_all("model");
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] ld;
        logic       dsel;
        logic       blank;
        logic       clr;
        logic [7:0] e_cnt;
        logic       e_tick;
        logic       e_flag;
        logic [7:0] e_seg;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Directed vectors on the DIV=1 instance, starting from reset state.
        vecs[0] = '{2'b11, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 8'h3F};
        vecs[1] = '{2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h79};
        vecs[2] = '{2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h71};
        vecs[3] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hBF};
        vecs[4] = '{2'b11, 8'h3A, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0, 8'hBF};
        vecs[5] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0, 8'h77};
        vecs[6] = '{2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0, 8'h4F};
        vecs[7] = '{2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3A, 1'b0, 1'b0, 8'h00};

        model_reset();
        repeat (2) @(posedge clk_2);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Table: load/up-wrap with DIV=1 and display controls.
        for (int v = 0; v < 8; v++) begin
            mode = vecs[v].mode; ld8 = vecs[v].ld; dsel8 = vecs[v].dsel;
            blank = vecs[v].blank; clr_flag = vecs[v].clr;
            cycle();
            chk($sformatf("vec%0d_cnt", v), int'(count_b), int'(vecs[v].e_cnt));
            chk($sformatf("vec%0d_tick", v), int'(tick_b), int'(vecs[v].e_tick));
            chk($sformatf("vec%0d_flag", v), int'(flag_b), int'(vecs[v].e_flag));
            chk($sformatf("vec%0d_seg", v), int'(seg_b), int'(vecs[v].e_seg));
        end
        blank = 1'b0; dsel8 = 1'b0;

        // Down wrap with DIV=4 on instance a.
        mode = 2'b11; ld8 = 8'h01;
        cycle();
        chk("down_load", int'(count_a), 'h01);
        mode = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk($sformatf("down_cnt%0d", k), int'(count_a), (k < 4) ? 'h01 : (k < 8) ? 'h00 : 'hFF);
            chk($sformatf("down_tick%0d", k), int'(tick_a), (k == 4 || k == 8) ? 1 : 0);
        end
        chk("down_flag", int'(flag_a), 1);
        mode = 2'b00; dsel8 = 1'b1;
        cycle();
        chk("down_seg", int'(seg_a), 'hF1);
        dsel8 = 1'b0;

        // Wrap and clr_flag in the same cycle on instance b.
        mode = 2'b11; ld8 = 8'hFF;
        cycle();
        mode = 2'b01; clr_flag = 1'b1;
        cycle();
        chk("race_cnt", int'(count_b), 'h00);
        chk("race_flag", int'(flag_b), 1);
        mode = 2'b00;
        cycle();
        chk("clr_flag", int'(flag_b), 0);
        chk("clr_cnt", int'(count_b), 'h00);
        clr_flag = 1'b0;

        // 12-bit display: upper nibble and out-of-range digit.
        mode = 2'b11; ld12 = 12'h5A3; dsel12 = 2'd2;
        cycle();
        mode = 2'b00;
        cycle();
        chk("c_dig2", int'(seg_c), 'h6D);
        dsel12 = 2'd3;
        cycle();
        chk("c_dig3", int'(seg_c), 'h00);
        dsel12 = 2'd0;

        // Hold mid-prescale clears the prescaler on instance a.
        mode = 2'b11; ld8 = 8'h00;
        cycle();
        mode = 2'b01;
        repeat (2) cycle();
        chk("hold_pre_cnt", int'(count_a), 0);
        mode = 2'b00;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("hold_tick%0d", k), int'(tick_a), 0);
        end
        mode = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk($sformatf("resume_tick%0d", k), int'(tick_a), (k == 4) ? 1 : 0);
            chk($sformatf("resume_cnt%0d", k), int'(count_a), (k == 4) ? 1 : 0);
        end

        // Asynchronous reset in the middle of counting.
        mode = 2'b01;
        repeat (9) cycle();
        reset_n = 1'b0;
        #2;
        model_reset();
        chk("async_cnt", int'(count_a), 0);
        chk("async_seg", int'(seg_a), 0);
        chk("async_flag", int'(flag_a), 0);
        check_all("async");
        #1;
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            mode = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : ((r & 1) != 0) ? 2'b01 : 2'b10;
            ld8 = 8'($urandom);
            ld12 = 12'($urandom);
            dsel8 = 1'($urandom);
            dsel12 = 2'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            clr_flag = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
